pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Consumer side of the PLL lock interface. Runs on the free-running 50 MHz reference clock.
//  Drives the PLL's active-high rst and watches its async locked output.
//  Releases the core reset (sys_rst_n) only after lock has been stable for a programmed window.
//  On lock loss it re-resets the core and re-cycles the PLL.
// PARAMETERS
//  RST_PULSE_CYC    16      cycles pll_rst is held high per PLL reset attempt (>=1)
//  LOCK_STABLE_CYC  1024    consecutive synced-locked cycles required before core release (>=1)
//  LOCK_TIMEOUT_CYC 500000  cycles allowed in WAIT_LOCK before a retry (10 ms at 50 MHz)
//  SYNC_STAGES      2       flops in the pll_locked synchroniser (>=2)
//  CNT_W            20      shared counter width; must hold max of the three *_CYC values
// PORTS
//  refclk      in   1  reference clock (50 MHz), sole clock
//  rst_n       in   1  reset: asynchronous assert, active-low
//  pll_locked  in   1  PLL locked output, asynchronous to refclk
//  pll_rst     out  1  active-high reset to the PLL
//  sys_rst_n   out  1  active-low core reset, registered
//  ready       out  1  high only in RUN state
//  lock_lost   out  1  one-cycle pulse when lock drops in RUN
//  retry_cnt   out  4  count of lock timeouts, saturating at 15
// BEHAVIOUR
//  Reset values (rst_n=0, async, effective immediately, also mid-operation):
//   state=PLL_RST, cnt=0, pll_rst=1, sys_rst_n=0, ready=0, lock_lost=0,
//   retry_cnt=0, sync chain=0.
//  lock_s = pll_locked after SYNC_STAGES flops. All FSM decisions use lock_s only.
//  States:
//   PLL_RST    pll_rst=1. cnt counts 0..RST_PULSE_CYC-1, then -> WAIT_LOCK with cnt=0.
//              pll_rst is high exactly RST_PULSE_CYC cycles.
//   WAIT_LOCK  pll_rst=0. If lock_s=1 -> STABLE with cnt=0.
//              Timeout: see CONFIGURATION.
//   STABLE     If lock_s=0 -> WAIT_LOCK with cnt=0; retry_cnt unchanged.
//              If cnt reaches LOCK_STABLE_CYC-1 with lock_s=1 -> RUN.
//   RUN        sys_rst_n=1, ready=1.
//              lock_s=0 -> PLL_RST, cnt=0, lock_lost=1 for that single transition cycle.
//  Output timing:
//   - sys_rst_n and ready are registered from state: high the cycle after entry to RUN;
//     low the cycle after leaving RUN.
//   - Lock drop in RUN: lock_s low at cycle N -> sys_rst_n=0, ready=0, lock_lost=1,
//     pll_rst=1 at N+1.
//   - sys_rst_n is never high outside RUN.
//  Counter and priority rules:
//   - cnt clears on every state change; otherwise increments.
//   - cnt saturates at 2^CNT_W-1 and never wraps.
//   - Simultaneous lock_s rise and timeout in WAIT_LOCK: lock wins -> STABLE, no retry.
//   - retry_cnt increments by 1 per timeout, holds at 15, cleared only by rst_n.
//   - Lock glitches shorter than the sync latency may be missed. This is accepted;
//     the STABLE window filters them.
// CONFIGURATION
//  Macro PLL_LOCK_TIMEOUT_EN:
//   defined:     in WAIT_LOCK, cnt reaching LOCK_TIMEOUT_CYC-1 with lock_s=0 ->
//                PLL_RST, cnt=0, retry_cnt+1 (saturating).
//   not defined: WAIT_LOCK waits indefinitely; retry_cnt is tied to 0;
//                LOCK_TIMEOUT_CYC is unused.
// TESTING  (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, SYNC_STAGES=2)
//  1. Release rst_n, pll_locked=0 -> pll_rst high exactly 4 cycles; sys_rst_n=0, ready=0.
//  2. pll_locked=1 held after pll_rst falls -> sys_rst_n=1, ready=1 at
//     2 (sync) + 8 (stable) + 1 cycles after the rise.
//  3. In RUN, drop pll_locked -> 3 cycles later: lock_lost 1-cycle pulse,
//     sys_rst_n=0, pll_rst=1 for 4 cycles; recovery repeats case 2.
//  4. In STABLE, pulse pll_locked low 3 cycles -> back to WAIT_LOCK; sys_rst_n stays 0;
//     retry_cnt unchanged; stable count restarts from 0.
//  5. PLL_LOCK_TIMEOUT_EN defined, pll_locked=0 forever -> PLL_RST re-entered every 36 cycles;
//     retry_cnt counts 1..15 and stays 15. Undefined build: retry_cnt=0, pll_rst low forever.
//  6. Assert rst_n mid-RUN -> all outputs take reset values asynchronously in the same cycle;
//     after release the sequence restarts from PLL_RST.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer_if
// Description : Bundle of the PLL lock handshake and the core-reset outputs
//               exchanged between pll_reset_sequencer and its surroundings.
//
//               Signals
//                 pll_locked  PLL locked indication, asynchronous to refclk
//                 pll_rst     active-high reset to the PLL
//                 sys_rst_n   active-low core reset, registered
//                 ready       high only while the sequencer is in RUN
//                 lock_lost   one-cycle pulse when lock drops in RUN
//                 retry_cnt   saturating count of lock timeouts
//
//               Modports
//                 master  the sequencer: samples pll_locked, drives the rest
//                 slave   the PLL / core side: drives pll_locked
// Revision    : 1.0  initial release
// ============================================================================
interface pll_reset_sequencer_if;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   modport master (
      input  pll_locked,
      output pll_rst,
      output sys_rst_n,
      output ready,
      output lock_lost,
      output retry_cnt
   );

   modport slave (
      output pll_locked,
      input  pll_rst,
      input  sys_rst_n,
      input  ready,
      input  lock_lost,
      input  retry_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Consumer side of the PLL lock interface, clocked by the
//               free-running reference clock. Pulses the PLL reset, waits
//               for lock, requires lock to stay asserted for a programmed
//               window, then releases the core reset. A lock drop while
//               running re-resets the core and re-cycles the PLL.
//
//               Ports
//                 refclk  in   reference clock, sole clock
//                 rst_n   in   asynchronous active-low reset
//                 pll     master modport of pll_reset_sequencer_if
//                         (pll_locked in; pll_rst, sys_rst_n, ready,
//                          lock_lost, retry_cnt out)
//
//               Parameters
//                 RST_PULSE_CYC     cycles pll_rst is high per attempt
//                 LOCK_STABLE_CYC   consecutive locked cycles before release
//                 LOCK_TIMEOUT_CYC  cycles in WAIT_LOCK before a retry
//                 SYNC_STAGES       depth of the pll_locked synchroniser
//                 CNT_W             width of the shared phase counter
//
//               Build option
//                 PLL_LOCK_TIMEOUT_EN  when defined, WAIT_LOCK gives up after
//                 LOCK_TIMEOUT_CYC cycles, re-pulses the PLL reset and counts
//                 the retry. When undefined, WAIT_LOCK waits indefinitely and
//                 retry_cnt is constant zero.
// Revision    : 1.0  initial release
// ============================================================================
module pll_reset_sequencer #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 500000,
   parameter int SYNC_STAGES      = 2,
   parameter int CNT_W            = 20
) (
   input  wire logic              refclk,
   input  wire logic              rst_n,
   pll_reset_sequencer_if.master  pll
);

   // -------------------------------------------------------------------------
   // Configuration sanity. The counter must be able to represent the largest
   // programmed window; the timeout window is included even when the timeout
   // is compiled out so one parameter set is valid for both builds.
   // -------------------------------------------------------------------------
   localparam longint MAX_CYC =
      (RST_PULSE_CYC >= LOCK_STABLE_CYC) ?
         ((RST_PULSE_CYC >= LOCK_TIMEOUT_CYC) ? longint'(RST_PULSE_CYC)
                                              : longint'(LOCK_TIMEOUT_CYC)) :
         ((LOCK_STABLE_CYC >= LOCK_TIMEOUT_CYC) ? longint'(LOCK_STABLE_CYC)
                                                : longint'(LOCK_TIMEOUT_CYC));
   localparam longint CNT_CAP = (longint'(1) << CNT_W) - 1;

   generate
      if (SYNC_STAGES < 2 || RST_PULSE_CYC < 1 || LOCK_STABLE_CYC < 1 ||
          CNT_CAP < MAX_CYC) begin : g_bad_cfg
         $error("pll_reset_sequencer: invalid parameter combination");
      end
   endgenerate

   // Terminal counter values: the last cycle spent in each timed phase.
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic [SYNC_STAGES-1:0]  sync;
   logic                    lock_s;
   logic                    lost_nxt;
   logic                    timeout_hit;

   // -------------------------------------------------------------------------
   // pll_locked synchroniser. Every FSM decision uses only the last stage, so
   // lock glitches shorter than the chain latency may be lost; the STABLE
   // window exists to filter whatever does get through.
   // -------------------------------------------------------------------------
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pll.pll_locked};
      end
   end

   assign lock_s = sync[SYNC_STAGES-1];

   // -------------------------------------------------------------------------
   // Lock timeout. Lock is checked before the timeout in the FSM, so a lock
   // arriving on the final timeout cycle still proceeds to STABLE.
   // -------------------------------------------------------------------------
`ifdef PLL_LOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

   logic [3:0] retry_q;

   assign timeout_hit = (state == ST_WAIT_LOCK) && !lock_s &&
                        (cnt == TIMEOUT_LAST);

   // Saturating retry counter; only the external reset clears it.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         retry_q <= 4'd0;
      end else if (timeout_hit && (retry_q != 4'hF)) begin
         retry_q <= retry_q + 4'd1;
      end
   end

   assign pll.retry_cnt = retry_q;
`else
   assign timeout_hit   = 1'b0;
   assign pll.retry_cnt = 4'd0;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic. The counter runs in every state and restarts from zero
   // on any state change; it saturates rather than wrapping so an unbounded
   // WAIT_LOCK can never alias onto a terminal value.
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      lost_nxt  = 1'b0;
      cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

      case (state)
         ST_PLL_RST: begin
            if (cnt == RST_LAST) begin
               state_nxt = ST_WAIT_LOCK;
            end
         end

         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = ST_STABLE;
            end else if (timeout_hit) begin
               state_nxt = ST_PLL_RST;
            end
         end

         ST_STABLE: begin
            if (!lock_s) begin
               state_nxt = ST_WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!lock_s) begin
               state_nxt = ST_PLL_RST;
               lost_nxt  = 1'b1;
            end
         end

         default: begin
            state_nxt = ST_PLL_RST;
         end
      endcase

      if (state_nxt != state) begin
         cnt_nxt = '0;
      end
   end

   // -------------------------------------------------------------------------
   // State register and registered outputs. The outputs are decoded from the
   // next state, so each one lines up exactly with the state it belongs to:
   // sys_rst_n/ready rise in the first RUN cycle and fall in the first cycle
   // after RUN, together with the lock_lost pulse and the new pll_rst pulse.
   // -------------------------------------------------------------------------
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_PLL_RST;
         cnt           <= '0;
         pll.pll_rst   <= 1'b1;
         pll.sys_rst_n <= 1'b0;
         pll.ready     <= 1'b0;
         pll.lock_lost <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         pll.pll_rst   <= (state_nxt == ST_PLL_RST);
         pll.sys_rst_n <= (state_nxt == ST_RUN);
         pll.ready     <= (state_nxt == ST_RUN);
         pll.lock_lost <= lost_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer. A timestamp-based
//               reference model (lock delay line + phase entry times) is
//               compared with the DUT on every falling clock edge; directed
//               scenarios pin the model with hand-computed latencies and
//               pulse widths, then randomized lock/reset activity follows.
//               Honours PLL_LOCK_TIMEOUT_EN the same way as the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pll_reset_sequencer;

   localparam int RST_PULSE_CYC    = 4;
   localparam int LOCK_STABLE_CYC  = 8;
   localparam int LOCK_TIMEOUT_CYC = 32;
   localparam int SYNC_STAGES      = 2;
   localparam int CNT_W            = 20;

`ifdef PLL_LOCK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // Model phases
   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_RUN  = 3;

   // Signal selectors for wait_until
   localparam int S_PLL_RST = 0;
   localparam int S_SYS     = 1;
   localparam int S_LOST    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pll_reset_sequencer_if bus ();

   pll_reset_sequencer #(
      .RST_PULSE_CYC    (RST_PULSE_CYC),
      .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
      .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
      .SYNC_STAGES      (SYNC_STAGES),
      .CNT_W            (CNT_W)
   ) dut (
      .refclk (clk),
      .rst_n  (rst_n),
      .pll    (bus)
   );

   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: lock_s is pll_locked seen through a SYNC_STAGES delay
   // line; each phase remembers the cycle it was entered, and the rules are
   // evaluated on elapsed time in the phase.
   // ------------------------------------------------------------------------
   int     m_phase;
   longint m_cyc;
   longint m_entry;
   int     m_retry;
   bit     m_lost;
   bit     lq[$];

   always @(posedge clk or negedge rst_n) begin : model
      bit ls;
      int el;
      int nph;
      if (!rst_n) begin
         m_phase = P_RST;
         m_cyc   = 0;
         m_entry = 0;
         m_retry = 0;
         m_lost  = 1'b0;
         lq      = {};
         for (int i = 0; i < SYNC_STAGES; i++) lq.push_back(1'b0);
      end else begin
         ls = lq.pop_front();
         lq.push_back(bus.pll_locked);
         el  = int'(m_cyc - m_entry);
         nph = m_phase;
         m_lost = 1'b0;
         case (m_phase)
            P_RST:  if (el >= RST_PULSE_CYC - 1) nph = P_WAIT;
            P_WAIT: begin
               if (ls) nph = P_STAB;
               else if (TO_EN && el >= LOCK_TIMEOUT_CYC - 1) begin
                  nph = P_RST;
                  if (m_retry < 15) m_retry++;
               end
            end
            P_STAB: begin
               if (!ls) nph = P_WAIT;
               else if (el >= LOCK_STABLE_CYC - 1) nph = P_RUN;
            end
            default: begin
               if (!ls) begin
                  nph = P_RST;
                  m_lost = 1'b1;
               end
            end
         endcase
         m_cyc++;
         if (nph != m_phase) begin
            m_phase = nph;
            m_entry = m_cyc;
         end
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("cyc pll_rst",   bus.pll_rst,   32'(m_phase == P_RST));
      check("cyc sys_rst_n", bus.sys_rst_n, 32'(m_phase == P_RUN));
      check("cyc ready",     bus.ready,     32'(m_phase == P_RUN));
      check("cyc lock_lost", bus.lock_lost, 32'(m_lost));
      check("cyc retry_cnt", bus.retry_cnt, 32'(m_retry));
   end

   function automatic logic sig(input int sel);
      case (sel)
         S_PLL_RST: return bus.pll_rst;
         S_SYS:     return bus.sys_rst_n;
         default:   return bus.lock_lost;
      endcase
   endfunction

   // Counts rising edges until the selected output equals val; -1 on timeout.
   task automatic wait_until(input int sel, input logic val, input int maxc,
                             output int n);
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         n++;
         if (sig(sel) === val) return;
         if (n >= maxc) begin
            n = -1;
            return;
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " pll_rst"},   bus.pll_rst,   1);
      check({tag, " sys_rst_n"}, bus.sys_rst_n, 0);
      check({tag, " ready"},     bus.ready,     0);
      check({tag, " lock_lost"}, bus.lock_lost, 0);
      check({tag, " retry_cnt"}, bus.retry_cnt, 0);
   endtask

   initial begin : watchdog
      #4000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      int len;
      bus.pll_locked = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");

      // 1: PLL reset pulse width after release
      rst_n = 1'b1;
      wait_until(S_PLL_RST, 1'b0, 100, n);
      check("t1 pll_rst width", n, RST_PULSE_CYC);
      check("t1 sys_rst_n", bus.sys_rst_n, 0);

      // 2: lock -> core release after sync + stable window + 1
      bus.pll_locked = 1'b1;
      wait_until(S_SYS, 1'b1, 100, n);
      check("t2 release latency", n, 11);
      check("t2 ready", bus.ready, 1);

      // 3: lock drop in RUN
      repeat (5) @(posedge clk);
      #1;
      bus.pll_locked = 1'b0;
      wait_until(S_LOST, 1'b1, 100, n);
      check("t3 lost latency", n, 3);
      check("t3 sys_rst_n", bus.sys_rst_n, 0);
      check("t3 ready", bus.ready, 0);
      check("t3 pll_rst", bus.pll_rst, 1);
      @(posedge clk);
      #1;
      check("t3 lost width", bus.lock_lost, 0);
      // one of the pll_rst cycles has already elapsed
      wait_until(S_PLL_RST, 1'b0, 100, n);
      check("t3 pll_rst width", n, RST_PULSE_CYC - 1);
      bus.pll_locked = 1'b1;
      wait_until(S_SYS, 1'b1, 100, n);
      check("t3 recovery latency", n, 11);

      // 4: glitch in STABLE restarts the window
      repeat (4) @(posedge clk);
      #1;
      bus.pll_locked = 1'b0;
      wait_until(S_LOST, 1'b1, 100, n);
      wait_until(S_PLL_RST, 1'b0, 100, n);
      repeat (3) @(posedge clk);
      #1;
      bus.pll_locked = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus.pll_locked = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.pll_locked = 1'b1;
      wait_until(S_SYS, 1'b1, 100, n);
      check("t4 restart latency", n, 11);
      check("t4 retry_cnt", bus.retry_cnt, 0);

      // 6: asynchronous reset mid-RUN
      repeat (3) @(posedge clk);
      #5;
      rst_n = 1'b0;
      #1;
      check_reset_values("t6 async");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_until(S_PLL_RST, 1'b0, 100, n);
      check("t6 restart pll_rst width", n, RST_PULSE_CYC);

      // 5: no lock at all
      bus.pll_locked = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_until(S_PLL_RST, 1'b0, 100, n);
      check("t5 first pll_rst width", n, RST_PULSE_CYC);
`ifdef PLL_LOCK_TIMEOUT_EN
      for (int k = 1; k <= 17; k++) begin
         wait_until(S_PLL_RST, 1'b1, 100, n);
         check("t5 timeout", n, LOCK_TIMEOUT_CYC);
         check("t5 retry_cnt", bus.retry_cnt, (k > 15) ? 15 : k);
         wait_until(S_PLL_RST, 1'b0, 100, n);
         check("t5 retry pll_rst width", n, RST_PULSE_CYC);
      end
`else
      repeat (200) @(posedge clk);
      #1;
      check("t5 pll_rst held low", bus.pll_rst, 0);
      check("t5 retry_cnt", bus.retry_cnt, 0);
      check("t5 sys_rst_n", bus.sys_rst_n, 0);
`endif

      // Randomized lock activity with occasional asynchronous resets
      for (int s = 0; s < 150; s++) begin
         if ($urandom_range(0, 29) == 0) begin
            #($urandom_range(1, 7));
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         bus.pll_locked = ($urandom_range(0, 3) != 0);
         len = bus.pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 12);
         repeat (len) @(posedge clk);
         #1;
      end

      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
